// File: rtl/cus19_branch_unit.sv
// cus19_branch_unit: execute-stage branch resolution for the Custom-19 CPU.
// Compares rs1/rs2 per funct code and registers the next-PC source select.
`default_nettype none

module cus19_branch_unit #(
  parameter int Data_Width = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [Data_Width-1:0] op1_in,
  input  logic [Data_Width-1:0] op2_in,
  input  logic                  branch_en_in,
  input  logic [3:0]            funct_in,
  input  logic                  flush_in,
  output logic [2:0]            pc_src_out,
  output logic                  taken_out,
  output logic                  illegal_out
);

  localparam logic [2:0] PC_SEQ  = 3'b000;
  localparam logic [2:0] PC_BR   = 3'b001;
  localparam logic [2:0] PC_JMP  = 3'b010;
  localparam logic [2:0] PC_CALL = 3'b011;
  localparam logic [2:0] PC_RET  = 3'b100;

  localparam logic [3:0] F_BEQ  = 4'd0;
  localparam logic [3:0] F_BNE  = 4'd1;
  localparam logic [3:0] F_BLT  = 4'd2;
  localparam logic [3:0] F_BGE  = 4'd3;
  localparam logic [3:0] F_BLTU = 4'd4;
  localparam logic [3:0] F_BGEU = 4'd5;
  localparam logic [3:0] F_JMP  = 4'd6;
  localparam logic [3:0] F_CALL = 4'd7;
  localparam logic [3:0] F_RET  = 4'd8;

  logic       eq;
  logic       lt_s;
  logic       lt_u;
  logic       cond;
  logic [2:0] pc_src_next;
  logic       illegal_next;

  assign eq   = (op1_in == op2_in);
  assign lt_s = ($signed(op1_in) < $signed(op2_in));
  assign lt_u = (op1_in < op2_in);

  always_comb begin
    cond         = 1'b0;
    pc_src_next  = PC_SEQ;
    illegal_next = 1'b0;
    if (branch_en_in && !flush_in) begin
      unique case (funct_in)
        F_BEQ:   cond = eq;
        F_BNE:   cond = !eq;
        F_BLT:   cond = lt_s;
        F_BGE:   cond = !lt_s;
        F_BLTU:  cond = lt_u;
        F_BGEU:  cond = !lt_u;
        F_JMP:   pc_src_next = PC_JMP;
        F_CALL:  pc_src_next = PC_CALL;
        F_RET:   pc_src_next = PC_RET;
        default: illegal_next = 1'b1;
      endcase
      if (cond) begin
        pc_src_next = PC_BR;
      end
    end
  end

  // taken is derived from the next select so both registers always agree.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_src_out  <= PC_SEQ;
      taken_out   <= 1'b0;
      illegal_out <= 1'b0;
    end else begin
      pc_src_out  <= pc_src_next;
      taken_out   <= |pc_src_next;
      illegal_out <= illegal_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cus19_branch_unit.sv
// Scoreboard bench for cus19_branch_unit: directed vectors, queued expectations.
`default_nettype none

module tb_cus19_branch_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] op1, op2;
  logic         branch_en;
  logic [3:0]   funct;
  logic         flush;
  logic [2:0]   pc_src;
  logic         taken;
  logic         illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] pc;
    logic       tk;
    logic       il;
    string      name;
  } exp_t;

  exp_t sb[$];

  cus19_branch_unit #(.Data_Width(W)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .op1_in      (op1),
    .op2_in      (op2),
    .branch_en_in(branch_en),
    .funct_in    (funct),
    .flush_in    (flush),
    .pc_src_out  (pc_src),
    .taken_out   (taken),
    .illegal_out (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] pc_e, input logic tk_e, input logic il_e);
    checks++;
    if (pc_src !== pc_e || taken !== tk_e || illegal !== il_e) begin
      failures++;
      $display("FAIL %s: got pc_src=%b taken=%b illegal=%b, expected pc_src=%b taken=%b illegal=%b",
               name, pc_src, taken, illegal, pc_e, tk_e, il_e);
    end
  endtask

  // Drive one decision on the falling edge; the next rising edge captures it.
  task automatic apply(input string name, input logic en, input logic [3:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic fl,
                       input logic [2:0] pc_e, input logic tk_e, input logic il_e);
    exp_t e;
    @(negedge clk);
    branch_en = en; funct = f; op1 = a; op2 = b; flush = fl;
    e.pc = pc_e; e.tk = tk_e; e.il = il_e; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected results never observed, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb.size() != 0) begin
        e = sb.pop_front();
        check(e.name, e.pc, e.tk, e.il);
      end
    end
  end

  initial begin
    rst = 1'b1; branch_en = 1'b0; funct = 4'd0; op1 = '0; op2 = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    //     name           en  funct  op1    op2    fl  pc      tk    il
    apply("beq_eq",       1, 4'h0, 8'd10, 8'd10, 0, 3'b001, 1'b1, 1'b0);
    apply("beq_ne",       1, 4'h0, 8'd5,  8'd7,  0, 3'b000, 1'b0, 1'b0);
    apply("bne_ne",       1, 4'h1, 8'd20, 8'd25, 0, 3'b001, 1'b1, 1'b0);
    apply("bne_eq",       1, 4'h1, 8'd30, 8'd30, 0, 3'b000, 1'b0, 1'b0);
    apply("disabled",     0, 4'h0, 8'd40, 8'd40, 0, 3'b000, 1'b0, 1'b0);
    apply("blt_signed",   1, 4'h2, 8'hF0, 8'h10, 0, 3'b001, 1'b1, 1'b0);
    apply("bge_signed",   1, 4'h3, 8'hF0, 8'h10, 0, 3'b000, 1'b0, 1'b0);
    apply("bltu",         1, 4'h4, 8'hF0, 8'h10, 0, 3'b000, 1'b0, 1'b0);
    apply("bgeu",         1, 4'h5, 8'hF0, 8'h10, 0, 3'b001, 1'b1, 1'b0);
    apply("bge_equal",    1, 4'h3, 8'h80, 8'h80, 0, 3'b001, 1'b1, 1'b0);
    apply("blt_minmax",   1, 4'h2, 8'h80, 8'h7F, 0, 3'b001, 1'b1, 1'b0);
    apply("bltu_minmax",  1, 4'h4, 8'h80, 8'h7F, 0, 3'b000, 1'b0, 1'b0);
    apply("bgeu_zero",    1, 4'h5, 8'h00, 8'hFF, 0, 3'b000, 1'b0, 1'b0);
    apply("jmp",          1, 4'h6, 8'd1,  8'd2,  0, 3'b010, 1'b1, 1'b0);
    apply("call",         1, 4'h7, 8'd1,  8'd2,  0, 3'b011, 1'b1, 1'b0);
    apply("ret",          1, 4'h8, 8'd1,  8'd2,  0, 3'b100, 1'b1, 1'b0);
    apply("illegal_a",    1, 4'hA, 8'd3,  8'd3,  0, 3'b000, 1'b0, 1'b1);
    apply("illegal_f",    1, 4'hF, 8'd0,  8'd0,  0, 3'b000, 1'b0, 1'b1);
    apply("illegal_dis",  0, 4'h9, 8'd0,  8'd0,  0, 3'b000, 1'b0, 1'b0);
    apply("flush_beq",    1, 4'h0, 8'd10, 8'd10, 1, 3'b000, 1'b0, 1'b0);
    apply("flush_illeg",  1, 4'hC, 8'd0,  8'd0,  1, 3'b000, 1'b0, 1'b0);
    apply("flush_jmp",    1, 4'h6, 8'd0,  8'd0,  1, 3'b000, 1'b0, 1'b0);
    apply("after_flush",  1, 4'h7, 8'd0,  8'd0,  0, 3'b011, 1'b1, 1'b0);
    drain();

    // Asynchronous reset mid-cycle after a taken BEQ.
    apply("pre_reset",    1, 4'h0, 8'd10, 8'd10, 0, 3'b001, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", 3'b000, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    branch_en = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset", 3'b000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cus19_branch_unit.md
Name: cus19_branch_unit

Overview:
- Branch-resolution unit of the Custom-19 CPU execute stage.
- Compares two register operands according to a 4-bit branch function code and produces the PC-source select for the fetch stage's next-PC mux.
- The result is registered, so the PC mux sees it one clock after the operands are presented.
- Also flags taken branches and illegal function codes.

Parameters:
- Data_Width, 8, width of the compared operands (valid range 2 to 32).

Ports:
- clk_in  input  1  system clock, rising-edge.
- rst_in  input  1  asynchronous, active-high reset.
- op1_in  input  Data_Width  first compare operand (rs1).
- op2_in  input  Data_Width  second compare operand (rs2).
- branch_en_in  input  1  current instruction is a branch/jump class instruction.
- funct_in  input  4  branch function code.
- flush_in  input  1  pipeline flush; squashes the decision for this cycle.
- pc_src_out  output  3  registered next-PC source select.
- taken_out  output  1  registered; 1 when pc_src_out is not 000.
- illegal_out  output  1  registered; branch_en_in was high with an undefined funct_in.

Behaviour:
- Reset: rst_in high, asynchronously, forces pc_src_out=000, taken_out=0, illegal_out=0. Outputs hold these values while rst_in is high. Normal operation resumes at the first rising edge after deassertion.
- Latency: one cycle. Inputs sampled at rising edge N appear on the outputs after edge N. There is no handshake; a new decision is made every cycle.
- pc_src encoding:
  - 000 = PC+1 (sequential)
  - 001 = conditional branch target
  - 010 = unconditional jump target
  - 011 = call target (fetch stage pushes return address)
  - 100 = return (pop return address)
  - 101–111 are never driven.
- funct_in decode (evaluated only when branch_en_in=1):
  - 0000 BER: equal → 001, else 000.
  - 0001 BNE: not equal → 001, else 000.
  - 0010 BLT: signed op1<op2 → 001, else 000.
  - 0011 BGE: signed op1>=op2 → 001, else 000.
  - 0100 BLTU: unsigned op1<op2 → 001, else 000.
  - 0101 BGEU: unsigned op1>=op2 → 001, else 000.
  - 0110 JMP: always 010.
  - 0111 CALL: always 011.
  - 1000 RET: always 100.
  - 1001–1111: pc_src 000, illegal_out=1 for that cycle.
- Comparison width rules:
  - Signed compares treat operands as two's complement, MSB = bit Data_Width-1.
  - Unsigned compares use the full width.
  - No operand extension; operands must be the same width.
- branch_en_in=0: pc_src 000, taken 0, illegal 0, regardless of funct_in and operands.
- flush_in=1: overrides everything except reset. Next outputs are 000/0/0, including for illegal codes.
- taken_out equals the OR-reduction of the next pc_src value; it is registered together with pc_src_out.
- Back-to-back branches are each resolved independently every cycle; the block holds no other state.

Test Plan:
- Reset: assert rst_in mid-cycle after a taken BER → pc_src_out=000, taken_out=0 immediately, before any clock edge.
- BER (Data_Width=8), branch_en=1, funct=0000:
  - op1=10, op2=10 → pc_src_out=001, taken_out=1 after one edge.
  - op1=5, op2=7 → 000, taken_out=0.
- BNE, funct=0001:
  - op1=20, op2=25 → 001.
  - op1=30, op2=30 → 000.
- Branch disabled: branch_en=0, funct=0000, op1=op2=40 → 000, taken_out=0.
- Signed vs unsigned compare, op1=8'hF0, op2=8'h10:
  - BLT (0010) → 001.
  - BLTU (0100) → 000.
  - BGEU (0101) → 001.
- Jump class, illegal code and flush:
  - JMP → 010; CALL → 011; RET → 100.
  - funct=1010 with branch_en=1 → 000, illegal_out=1.
  - Taken BER with flush_in=1 → 000, taken_out=0.
